rgb_pwm_out: RTL and testbench
==============================

// Module: rgb_pwm_out
// PURPOSE
//  Three-channel LED PWM generator; direct consumer of the per-channel ramp blocks' pwm_value.
//  One shared period counter; each channel compares it against a shadowed, clamped duty.
//  Duty updates apply only at a period boundary, so a ramp change never produces a runt pulse.
//  Outputs drive the R/G/B LED pins at the top level.
// PARAMETERS
//  PERIOD    100000  clocks per PWM period; duty == PERIOD means 100% on (min 2)
//  CNT_W     $clog2(PERIOD+1)  width of counter and shadow duty (derived; do not override)
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      reset, asynchronous assert, active-low
//  duty_r        in   32     red duty from ramp block (signed int, clocks of on-time)
//  duty_g        in   32     green duty (signed int)
//  duty_b        in   32     blue duty (signed int)
//  hold          in   1      1 = freeze shadow duties at next boundary (no reload)
//  pwm_r         out  1      red LED drive
//  pwm_g         out  1      green LED drive
//  pwm_b         out  1      blue LED drive
//  period_start  out  1      one-cycle strobe, first cycle of each period
// BEHAVIOUR
//  - Reset (rst_n=0, async): cnt=0, all shadows=0, period_start=0, pwm_* = OFF level.
//    Reset mid-period forces outputs OFF immediately; after release, counting restarts at cnt=0.
//  - Counter: cnt counts 0..PERIOD-1, wraps to 0; never stalls.
//  - Boundary: when cnt==PERIOD-1 and hold==0, every shadow loads clamp(duty_x), sampled that cycle.
//    hold==1 on that cycle: shadows keep their values for the whole next period.
//  - Clamp: duty<0 -> 0; duty>PERIOD -> PERIOD; otherwise unchanged. Done in 32-bit signed,
//    then truncated to CNT_W; no wrap-around of large values.
//  - Compare: on_x = (cnt < shadow_x). Outputs registered: pwm_x(t+1) = ON when on_x(t).
//    Latency: a duty sampled at cnt==PERIOD-1 is first visible on pwm_x one cycle after cnt==0.
//  - shadow==0: output OFF all period; shadow==PERIOD: ON all period, no gap at wrap.
//  - period_start registered: high exactly one cycle, aligned with first output cycle of period.
//  - Inputs may change on any cycle; only the boundary-cycle value matters.
//  - ON level = 1, OFF level = 0 (see CONFIGURATION).
// CONFIGURATION
//  PWM_ACTIVE_LOW_EN defined: ON level = 0, OFF level = 1 (common-anode LEDs); reset drives 1s.
//  Not defined: active-high outputs as above. Strobe polarity never changes.
// STRUCTURE
//  Package pwm_pkg: localparam PWM_PERIOD_DEF=100000; typedef logic signed [31:0] duty_in_t;
//    function clamp_duty(duty_in_t d, int period) returning int.
//  Sub-module pwm_channel (instantiated x3): clamp + shadow reg + compare + output flop;
//    inputs clk, rst_n, cnt, load, duty; output pwm. Counter and strobe live in top.
// TESTING (bench uses PERIOD=10)
//  1 duty_r=3 steady -> pwm_r high 3 cycles, low 7, repeating; period_start every 10 cycles.
//  2 duty_g=0 then 10 -> green constant OFF, then constant ON with no low cycle across wrap.
//  3 duty_b=-5 and 100000 -> clamp to 0 (always OFF) and 10 (always ON).
//  4 change duty_r 3->7 at cnt=5 -> current period finishes at 3; next period shows 7.
//  5 hold=1 over boundary while duty_r 3->7 -> period stays 3; 7 appears after a boundary with hold=0.
//  6 rst_n low at cnt=2 with pwm high -> pwm OFF same cycle; after release, full period from cnt=0;
//    repeat 1 and 6 with PWM_ACTIVE_LOW_EN -> inverted levels, reset outputs 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types, defaults and duty clamp for the RGB PWM generator.
// Output polarity is selected by PWM_ACTIVE_LOW_EN (defined: ON=0 for common-anode LEDs).
package pwm_pkg;

   localparam int PWM_PERIOD_DEF = 100000;

   typedef logic signed [31:0] duty_in_t;

`ifdef PWM_ACTIVE_LOW_EN
   localparam logic PWM_ON  = 1'b0;
   localparam logic PWM_OFF = 1'b1;
`else
   localparam logic PWM_ON  = 1'b1;
   localparam logic PWM_OFF = 1'b0;
`endif

   // Saturate in signed 32-bit so huge requests pin to full-on instead of wrapping.
   function automatic int clamp_duty(input duty_in_t d, input int period);
      int r;
      if (d < 32'sd0) begin
         r = 32'sd0;
      end else if (d > period) begin
         r = period;
      end else begin
         r = int'(d);
      end
      return r;
   endfunction

endpackage

// File: rtl/rgb_pwm_out_if.sv
// Duty/hold inputs and LED/strobe outputs of the RGB PWM generator.
// Output levels follow PWM_ACTIVE_LOW_EN; the strobe is always active-high.
interface rgb_pwm_out_if;
   import pwm_pkg::*;

   duty_in_t duty_r;
   duty_in_t duty_g;
   duty_in_t duty_b;
   logic     hold;
   logic     pwm_r;
   logic     pwm_g;
   logic     pwm_b;
   logic     period_start;

   modport master (
      output duty_r, duty_g, duty_b, hold,
      input  pwm_r, pwm_g, pwm_b, period_start
   );

   modport slave (
      input  duty_r, duty_g, duty_b, hold,
      output pwm_r, pwm_g, pwm_b, period_start
   );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: clamp, boundary-loaded shadow duty, compare and output flop.
// ON/OFF levels come from pwm_pkg (PWM_ACTIVE_LOW_EN).
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int PERIOD = PWM_PERIOD_DEF,
   parameter int CNT_W  = $clog2(PERIOD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cnt,
   input  logic             load,
   input  duty_in_t         duty,
   output logic             pwm
);

   logic [CNT_W-1:0] w_clamp;
   logic [CNT_W-1:0] r_shadow;
   logic             r_pwm;

   // Clamped duty, already within 0..PERIOD so truncation is lossless.
   always_comb begin
      w_clamp = CNT_W'(clamp_duty(duty, PERIOD));
   end

   // Shadow only changes on the boundary cycle, so a period is never cut short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= {CNT_W{1'b0}};
         r_pwm    <= PWM_OFF;
      end else begin
         if (load) begin
            r_shadow <= w_clamp;
         end else begin
            r_shadow <= r_shadow;
         end
         r_pwm <= (cnt < r_shadow) ? PWM_ON : PWM_OFF;
      end
   end

   assign pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_out.sv
// Three-channel LED PWM with one shared period counter and a period-start strobe.
// Define PWM_ACTIVE_LOW_EN for inverted (common-anode) LED drive levels.
module rgb_pwm_out
   import pwm_pkg::*;
#(
   parameter int PERIOD = PWM_PERIOD_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   rgb_pwm_out_if.slave  bus
);

   localparam int               CNT_W    = $clog2(PERIOD + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_period_start;
   logic             w_load;
   logic             w_pwm_r;
   logic             w_pwm_g;
   logic             w_pwm_b;

   // Free-running period counter, 0..PERIOD-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= {CNT_W{1'b0}};
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Strobe lines up with the first registered output cycle of each period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= (r_cnt == {CNT_W{1'b0}});
      end
   end

   assign w_load = (r_cnt == CNT_LAST) && !bus.hold;

   pwm_channel #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_ch_r (
      .clk(clk), .rst_n(rst_n), .cnt(r_cnt), .load(w_load), .duty(bus.duty_r), .pwm(w_pwm_r)
   );
   pwm_channel #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_ch_g (
      .clk(clk), .rst_n(rst_n), .cnt(r_cnt), .load(w_load), .duty(bus.duty_g), .pwm(w_pwm_g)
   );
   pwm_channel #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_ch_b (
      .clk(clk), .rst_n(rst_n), .cnt(r_cnt), .load(w_load), .duty(bus.duty_b), .pwm(w_pwm_b)
   );

   assign bus.pwm_r        = w_pwm_r;
   assign bus.pwm_g        = w_pwm_g;
   assign bus.pwm_b        = w_pwm_b;
   assign bus.period_start = r_period_start;

endmodule

// File: tb/tb_rgb_pwm_out.sv
// Directed bench for rgb_pwm_out with PERIOD=10; expected levels follow PWM_ACTIVE_LOW_EN.
module tb_rgb_pwm_out;

   localparam int P = 10;
`ifdef PWM_ACTIVE_LOW_EN
   localparam logic ON  = 1'b0;
   localparam logic OFF = 1'b1;
`else
   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;
`endif

   typedef struct {
      string              name;
      logic signed [31:0] dr;
      logic signed [31:0] dg;
      logic signed [31:0] db;
      int                 er;
      int                 eg;
      int                 eb;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[8];

   rgb_pwm_out_if bus();

   rgb_pwm_out #(.PERIOD(P)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called on the first output cycle of a period; leaves on the first cycle of the next.
   task automatic check_period(input string name, input int er, input int eg, input int eb);
      for (int k = 0; k < P; k++) begin
         chk($sformatf("%s_r_k%0d", name, k), bus.pwm_r, (k < er) ? ON : OFF);
         chk($sformatf("%s_g_k%0d", name, k), bus.pwm_g, (k < eg) ? ON : OFF);
         chk($sformatf("%s_b_k%0d", name, k), bus.pwm_b, (k < eb) ? ON : OFF);
         chk($sformatf("%s_ps_k%0d", name, k), bus.period_start, (k == 0) ? 1'b1 : 1'b0);
         step();
      end
   endtask

   task automatic wait_ps(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * P && !seen; i++) begin
         step();
         if (bus.period_start === 1'b1) seen = 1'b1;
      end
      chk({name, "_ps_seen"}, seen, 1'b1);
   endtask

   initial begin
      vecs[0] = '{"r3",      32'sd3,          32'sd0,          32'sd0,      3,  0,  0};
      vecs[1] = '{"g10",     32'sd3,          32'sd10,         32'sd0,      3, 10,  0};
      vecs[2] = '{"b_neg",   32'sd3,          32'sd10,        -32'sd5,      3, 10,  0};
      vecs[3] = '{"b_big",   32'sd3,          32'sd10,         32'sd100000, 3, 10, 10};
      vecs[4] = '{"edges",   32'sd1,          32'sd9,          32'sd11,     1,  9, 10};
      vecs[5] = '{"extreme", 32'sh7FFFFFFF,   32'sh80000000,   32'sd10,    10,  0, 10};
      vecs[6] = '{"mid",     32'sd5,         -32'sd1,          32'sd0,      5,  0,  0};
      vecs[7] = '{"r3_back", 32'sd3,          32'sd0,          32'sd0,      3,  0,  0};

      bus.duty_r = 32'sd0;
      bus.duty_g = 32'sd0;
      bus.duty_b = 32'sd0;
      bus.hold   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pwm_r", bus.pwm_r, OFF);
      chk("rst_pwm_g", bus.pwm_g, OFF);
      chk("rst_pwm_b", bus.pwm_b, OFF);
      chk("rst_ps", bus.period_start, 1'b0);

      rst_n = 1'b1;
      step();
      check_period("post_reset", 0, 0, 0);

      foreach (vecs[i]) begin
         bus.duty_r = vecs[i].dr;
         bus.duty_g = vecs[i].dg;
         bus.duty_b = vecs[i].db;
         wait_ps(vecs[i].name);
         wait_ps(vecs[i].name);
         check_period(vecs[i].name, vecs[i].er, vecs[i].eg, vecs[i].eb);
         check_period({vecs[i].name, "_wrap"}, vecs[i].er, vecs[i].eg, vecs[i].eb);
      end

      // Mid-period duty change: current period keeps 3, next shows 7.
      for (int k = 0; k < P; k++) begin
         if (k == 4) bus.duty_r = 32'sd7;
         chk($sformatf("midchg_r_k%0d", k), bus.pwm_r, (k < 3) ? ON : OFF);
         chk($sformatf("midchg_ps_k%0d", k), bus.period_start, (k == 0) ? 1'b1 : 1'b0);
         step();
      end
      check_period("after_change", 7, 0, 0);

      // Hold across one boundary keeps the old shadow for a whole extra period.
      bus.duty_r = 32'sd3;
      check_period("pre_hold", 7, 0, 0);
      bus.hold   = 1'b1;
      bus.duty_r = 32'sd7;
      check_period("hold_p1", 3, 0, 0);
      bus.hold = 1'b0;
      check_period("hold_p2", 3, 0, 0);
      check_period("hold_p3", 7, 0, 0);

      // Async reset mid-period while red is on.
      step();
      chk("prerst_r_on", bus.pwm_r, ON);
      rst_n = 1'b0;
      #1;
      chk("midrst_r_off", bus.pwm_r, OFF);
      chk("midrst_ps", bus.period_start, 1'b0);
      repeat (2) begin
         step();
         chk("inrst_r_off", bus.pwm_r, OFF);
      end
      rst_n = 1'b1;
      step();
      check_period("rst_p0", 0, 0, 0);
      check_period("rst_p1", 7, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
